// File: rtl/ariane_pkg.sv
// Shared scoreboard types and sizing for the ID/EX/WB pipeline.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES   = 8;
  localparam int unsigned TRANS_ID_BITS   = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS     = 3;
  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/commit_prefix_cnt.sv
// Leading-ones count: how many consecutive commit slots, from slot 0, retire this cycle.
module commit_prefix_cnt #(
  parameter int unsigned N    = 2,
  parameter int unsigned CntW = $clog2(N + 1)
) (
  input  logic [N-1:0]    mask_i,
  output logic [CntW-1:0] cnt_o
);

  logic run;

  always_comb begin
    cnt_o = '0;
    run   = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      run = run & mask_i[k];
      if (run) cnt_o = cnt_o + CntW'(1);
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue, out-of-order writeback, in-order multi-commit scoreboard.
// Entries live in a circular buffer; an entry's buffer index is its trans_id.
module issue_scoreboard
  import ariane_pkg::scoreboard_entry;
  import ariane_pkg::exception;
#(
  parameter int unsigned NR_ENTRIES      = ariane_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS     = ariane_pkg::NR_WB_PORTS,
  parameter int unsigned NR_COMMIT_PORTS = ariane_pkg::NR_COMMIT_PORTS,
  parameter int unsigned TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  output logic                       full_o,
  input  logic                       issue_valid_i,
  input  scoreboard_entry            issue_entry_i,
  output logic                       issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]   issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]     wb_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   wb_trans_id_i [NR_WB_PORTS],
  input  logic [63:0]                wb_result_i [NR_WB_PORTS],
  input  exception                   wb_ex_i [NR_WB_PORTS],
  output scoreboard_entry            commit_instr_o [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0] commit_valid_o,
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i
);

  localparam int unsigned CntW  = TRANS_ID_BITS + 1;
  localparam int unsigned NW    = $clog2(NR_COMMIT_PORTS + 1);
  localparam int unsigned SbIdW = ariane_pkg::TRANS_ID_BITS;

  scoreboard_entry            mem_q [NR_ENTRIES];
  scoreboard_entry            mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]      occ_q, occ_d;
  logic [TRANS_ID_BITS-1:0]   issue_ptr_q, issue_ptr_d;
  logic [TRANS_ID_BITS-1:0]   commit_ptr_q, commit_ptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       issue_fire;
  logic [NR_COMMIT_PORTS-1:0] retire_mask;
  logic [NW-1:0]              retire_n;
  logic [NR_ENTRIES-1:0]      wb_hit;
  logic                       slot_run;
  logic [TRANS_ID_BITS-1:0]   slot_idx;

  // Issue handshake looks at registered occupancy only: a retire in the same
  // cycle does not free a slot until the next cycle.
  assign full_o           = (cnt_q == CntW'(NR_ENTRIES));
  assign issue_ready_o    = !full_o;
  assign issue_trans_id_o = issue_ptr_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;

  always_comb begin
    slot_run = 1'b1;
    slot_idx = '0;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      slot_idx          = commit_ptr_q + TRANS_ID_BITS'(k);
      commit_instr_o[k] = mem_q[slot_idx];
      slot_run          = slot_run && (cnt_q > CntW'(k)) && mem_q[slot_idx].valid;
      commit_valid_o[k] = slot_run;
    end
  end

  assign retire_mask = commit_ack_i & commit_valid_o;

  commit_prefix_cnt #(
    .N    (NR_COMMIT_PORTS),
    .CntW (NW)
  ) u_prefix (
    .mask_i (retire_mask),
    .cnt_o  (retire_n)
  );

  always_comb begin
    mem_d        = mem_q;
    occ_d        = occ_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    wb_hit       = '0;
    if (flush_i) begin
      occ_d        = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      cnt_d        = '0;
    end else begin
      // Ascending scan with a hit mask: the lowest port claims a doubly-targeted id.
      for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
        if (wb_valid_i[p] && occ_q[wb_trans_id_i[p]] && !wb_hit[wb_trans_id_i[p]]) begin
          wb_hit[wb_trans_id_i[p]]       = 1'b1;
          mem_d[wb_trans_id_i[p]].result = wb_result_i[p];
          mem_d[wb_trans_id_i[p]].valid  = 1'b1;
          if (wb_ex_i[p].valid) mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
        end
      end
      for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
        if (NW'(k) < retire_n) occ_d[commit_ptr_q + TRANS_ID_BITS'(k)] = 1'b0;
      end
      commit_ptr_d = commit_ptr_q + TRANS_ID_BITS'(retire_n);
      if (issue_fire) begin
        mem_d[issue_ptr_q]          = issue_entry_i;
        mem_d[issue_ptr_q].trans_id = SbIdW'(issue_ptr_q);
        mem_d[issue_ptr_q].valid    = 1'b0;
        occ_d[issue_ptr_q]          = 1'b1;
        issue_ptr_d                 = issue_ptr_q + TRANS_ID_BITS'(1);
      end
      cnt_d = cnt_q + CntW'(issue_fire) - CntW'(retire_n);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) mem_q[i] <= '0;
      occ_q        <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
    end else begin
      mem_q        <= mem_d;
      occ_q        <= occ_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; retired entries are checked against an issue-order queue.
module tb_issue_scoreboard;
  import ariane_pkg::*;

  localparam int unsigned NE  = 8;
  localparam int unsigned NWB = 3;
  localparam int unsigned NC  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic                 full;
  logic                 issue_valid;
  scoreboard_entry      issue_entry;
  logic                 issue_ready;
  logic [2:0]           issue_trans_id;
  logic [NWB-1:0]       wb_valid;
  logic [2:0]           wb_id [NWB];
  logic [63:0]          wb_res [NWB];
  exception             wb_ex [NWB];
  scoreboard_entry      commit_instr [NC];
  logic [NC-1:0]        commit_valid;
  logic [NC-1:0]        commit_ack;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] pc;
    logic [63:0] res;
    logic        ex;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] m_pc [NE];
  logic [2:0]  m_ptr = '0;
  int          seq = 0;
  bit          mon_run;
  exp_t        mon_e;

  always #5 clk = ~clk;

  issue_scoreboard #(
    .NR_ENTRIES      (NE),
    .NR_WB_PORTS     (NWB),
    .NR_COMMIT_PORTS (NC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .full_o           (full),
    .issue_valid_i    (issue_valid),
    .issue_entry_i    (issue_entry),
    .issue_ready_o    (issue_ready),
    .issue_trans_id_o (issue_trans_id),
    .wb_valid_i       (wb_valid),
    .wb_trans_id_i    (wb_id),
    .wb_result_i      (wb_res),
    .wb_ex_i          (wb_ex),
    .commit_instr_o   (commit_instr),
    .commit_valid_o   (commit_valid),
    .commit_ack_i     (commit_ack)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] res_of(input logic [63:0] pc);
    return pc ^ 64'hC0DE_0000_0000_0000;
  endfunction

  function automatic logic ex_of(input logic [63:0] pc);
    return pc[3] & pc[2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input int p, input logic [2:0] id);
    wb_valid[p]       = 1'b1;
    wb_id[p]          = id;
    wb_res[p]         = res_of(m_pc[id]);
    wb_ex[p]          = '0;
    wb_ex[p].valid    = ex_of(m_pc[id]);
    wb_ex[p].cause    = m_pc[id];
  endtask

  // One clock: optional issue (exp_fire = expected handshake), commit acks, pending writebacks.
  task automatic step(input bit iv, input bit exp_fire, input logic [NC-1:0] ack);
    logic [63:0] pc;
    exp_t        e;
    commit_ack = ack;
    if (iv) begin
      pc                   = 64'h1000 + 64'(seq) * 4;
      issue_entry          = '0;
      issue_entry.pc       = pc;
      issue_entry.trans_id = 3'h5;
      issue_entry.valid    = 1'b1;
      issue_entry.rd       = 5'(seq);
      issue_valid          = 1'b1;
      cmp("issue_ready", 64'(issue_ready), 64'(exp_fire));
      if (exp_fire) begin
        cmp("issue_trans_id", 64'(issue_trans_id), 64'(m_ptr));
        m_pc[m_ptr] = pc;
        e.id  = m_ptr;
        e.pc  = pc;
        e.res = res_of(pc);
        e.ex  = ex_of(pc);
        exp_q.push_back(e);
        m_ptr++;
        seq++;
      end
    end
    tick();
    issue_valid = 1'b0;
    commit_ack  = '0;
    wb_valid    = '0;
  endtask

  // Retire monitor: follows the leading run of acked valid slots.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_run = 1'b1;
      for (int k = 0; k < int'(NC); k++) begin
        mon_run = mon_run && commit_valid[k] && commit_ack[k];
        if (mon_run) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL retire_unexpected: slot %0d id %0d, want no retire", k,
                     commit_instr[k].trans_id);
          end else begin
            mon_e = exp_q.pop_front();
            cmp("retire_id", 64'(commit_instr[k].trans_id), 64'(mon_e.id));
            cmp("retire_pc", commit_instr[k].pc, mon_e.pc);
            cmp("retire_result", commit_instr[k].result, mon_e.res);
            cmp("retire_ex", 64'(commit_instr[k].ex.valid), 64'(mon_e.ex));
          end
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_entry = '0;
    wb_valid    = '0;
    commit_ack  = '0;
    for (int p = 0; p < int'(NWB); p++) begin
      wb_id[p]  = '0;
      wb_res[p] = '0;
      wb_ex[p]  = '0;
    end
    for (int i = 0; i < int'(NE); i++) m_pc[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_ready", 64'(issue_ready), 64'd1);
    cmp("rst_trans_id", 64'(issue_trans_id), 64'd0);
    cmp("rst_full", 64'(full), 64'd0);
    cmp("rst_commit_valid", 64'(commit_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fill, then one stalled issue.
    for (int i = 0; i < 8; i++) begin
      cmp("fill_full", 64'(full), 64'd0);
      step(1'b1, 1'b1, 2'b00);
    end
    cmp("filled_full", 64'(full), 64'd1);
    step(1'b1, 1'b0, 2'b00);
    cmp("stall_full", 64'(full), 64'd1);
    cmp("stall_trans_id", 64'(issue_trans_id), 64'd0);
    cmp("fill_cv", 64'(commit_valid), 64'd0);
    cmp("fill_head_valid", 64'(commit_instr[0].valid), 64'd0);
    wb_set(0, 3'd0); wb_set(1, 3'd1); wb_set(2, 3'd2);
    step(1'b0, 1'b0, 2'b00);
    wb_set(0, 3'd3); wb_set(1, 3'd4); wb_set(2, 3'd5);
    step(1'b0, 1'b0, 2'b00);
    wb_set(0, 3'd6); wb_set(2, 3'd7);
    step(1'b0, 1'b0, 2'b00);
    cmp("fill_wb_cv", 64'(commit_valid), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b11);
    cmp("drain_full", 64'(full), 64'd0);
    cmp("drain_cv", 64'(commit_valid), 64'd0);
    cmp("drain_trans_id", 64'(issue_trans_id), 64'd0);

    // Out-of-order writeback: 2, 1, then 0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00);
    wb_set(0, 3'd2);
    step(1'b0, 1'b0, 2'b00);
    cmp("ooo_cv_a", 64'(commit_valid), 64'd0);
    wb_set(1, 3'd1);
    step(1'b0, 1'b0, 2'b00);
    cmp("ooo_cv_b", 64'(commit_valid), 64'd0);
    wb_set(2, 3'd0);
    step(1'b0, 1'b0, 2'b00);
    cmp("ooo_cv_c", 64'(commit_valid), 64'd3);
    cmp("ooo_slot0", 64'(commit_instr[0].trans_id), 64'd0);
    cmp("ooo_slot1", 64'(commit_instr[1].trans_id), 64'd1);
    step(1'b0, 1'b0, 2'b11);
    cmp("ooo_cv_tail", 64'(commit_valid), 64'd1);
    step(1'b0, 1'b0, 2'b11);
    cmp("ooo_cv_end", 64'(commit_valid), 64'd0);

    // Non-prefix ack.
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    wb_set(0, 3'd3); wb_set(1, 3'd4);
    step(1'b0, 1'b0, 2'b00);
    cmp("np_cv", 64'(commit_valid), 64'd3);
    step(1'b0, 1'b0, 2'b10);
    cmp("np_cv_hold", 64'(commit_valid), 64'd3);
    cmp("np_head", 64'(commit_instr[0].trans_id), 64'd3);
    step(1'b0, 1'b0, 2'b11);
    cmp("np_cv_end", 64'(commit_valid), 64'd0);

    // Dual commit across the wrap, with a full-buffer retire+issue collision.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'b00);
    cmp("wrap_full", 64'(full), 64'd1);
    wb_set(0, 3'd5); wb_set(1, 3'd6); wb_set(2, 3'd7);
    step(1'b0, 1'b0, 2'b00);
    wb_set(0, 3'd0); wb_set(1, 3'd1); wb_set(2, 3'd2);
    step(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11);
    cmp("wrap_cv_gap", 64'(commit_valid), 64'd0);
    cmp("wrap_head", 64'(commit_instr[0].trans_id), 64'd3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2'b00);
    cmp("wrap_refull", 64'(full), 64'd1);
    wb_set(0, 3'd3); wb_set(1, 3'd4);
    step(1'b0, 1'b0, 2'b00);
    cmp("coll_cv", 64'(commit_valid), 64'd3);
    step(1'b1, 1'b0, 2'b11);
    cmp("coll_full", 64'(full), 64'd0);
    cmp("coll_trans_id", 64'(issue_trans_id), 64'd3);
    step(1'b1, 1'b1, 2'b00);
    cmp("coll_full_after", 64'(full), 64'd0);
    wb_set(0, 3'd5); wb_set(1, 3'd6); wb_set(2, 3'd7);
    step(1'b0, 1'b0, 2'b00);
    wb_set(0, 3'd0); wb_set(1, 3'd1); wb_set(2, 3'd2);
    step(1'b0, 1'b0, 2'b00);
    wb_set(1, 3'd3);
    step(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b11);
    cmp("wrap_cv_end", 64'(commit_valid), 64'd0);
    cmp("wrap_trans_id", 64'(issue_trans_id), 64'd4);

    // Flush with 5 in flight plus concurrent writeback and issue.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b00);
    wb_set(0, 3'd4); wb_set(1, 3'd5);
    flush       = 1'b1;
    issue_valid = 1'b1;
    tick();
    flush       = 1'b0;
    issue_valid = 1'b0;
    wb_valid    = '0;
    exp_q.delete();
    m_ptr = '0;
    cmp("flush_cv", 64'(commit_valid), 64'd0);
    cmp("flush_trans_id", 64'(issue_trans_id), 64'd0);
    cmp("flush_full", 64'(full), 64'd0);
    wb_set(0, 3'd0);
    step(1'b0, 1'b0, 2'b00);
    cmp("flush_stale_wb", 64'(commit_valid), 64'd0);
    step(1'b1, 1'b1, 2'b00);
    cmp("post_flush_cv", 64'(commit_valid), 64'd0);
    cmp("post_flush_id", 64'(commit_instr[0].trans_id), 64'd0);
    // Two ports on one id: port 0 must win, port 1 carries a poisoned result.
    wb_set(0, 3'd0);
    wb_valid[1]       = 1'b1;
    wb_id[1]          = 3'd0;
    wb_res[1]         = ~res_of(m_pc[0]);
    wb_ex[1]          = '0;
    wb_ex[1].valid    = 1'b1;
    step(1'b0, 1'b0, 2'b00);
    cmp("prio_cv", 64'(commit_valid), 64'd1);
    step(1'b0, 1'b0, 2'b11);
    cmp("end_cv", 64'(commit_valid), 64'd0);
    cmp("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
